mem_split_arbiter: RTL and testbench

MEM_SPLIT_ARBITER -- requirements
Module: mem_split_arbiter

---
 rtl/mem_split_pkg.sv | 19 +
 rtl/mem_split_tag_fifo.sv | 48 ++++
 rtl/mem_split_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_split_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_split_pkg.sv
// Shared types and defaults for the split-transaction memory arbiter.
// Holds the master-index width helper and the read tag type.
package mem_split_pkg;

    localparam int NUM_MASTERS_DEF     = 4;
    localparam int ADDR_WIDTH_DEF      = 32;
    localparam int DATA_WIDTH_DEF      = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;

    // Wide enough for the largest supported master count (16).
    localparam int TAG_W = 4;

    typedef logic [TAG_W-1:0] tag_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_split_tag_fifo.sv
// In-order FIFO of master tags for reads awaiting a slave response.
// Pointers carry one extra wrap bit to tell full from empty.
module mem_split_tag_fifo
    import mem_split_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam int PW = idx_w(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    tag_t        mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_split_arbiter.sv
// Round-robin split-bus arbiter with locked grants and in-order read routing.
// MEM_SPLIT_ARBITER_RESP_REG_EN registers m_resp_o/m_rdata_o (1-cycle lag).
module mem_split_arbiter
    import mem_split_pkg::*;
#(
    parameter int NUM_MASTERS     = NUM_MASTERS_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    output logic [NUM_MASTERS-1:0]              m_resp_o,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [DATA_WIDTH-1:0]               m_rdata_o,
    output logic                                s_req_o,
    output logic                                s_we_o,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic [DATA_WIDTH-1:0]               s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             s_be_o,
    input  logic                                s_ack_i,
    input  logic                                s_resp_i,
    input  logic [DATA_WIDTH-1:0]               s_rdata_i,
    output logic                                err_o
);

    localparam int IW = idx_w(NUM_MASTERS);
    localparam int BW = DATA_WIDTH / 8;

    logic                   locked;
    logic [IW-1:0]          lock_idx;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_vld;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    tag_t                   head;
    logic                   err_q;
    logic [NUM_MASTERS-1:0] resp_vec;
    int                     j;

    // A locked grant is never re-arbitrated; reads are masked while full.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        if (locked) begin
            gnt_vld = m_req_i[lock_idx];
            gnt_idx = lock_idx;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                j = (int'(rr_ptr) + i) % NUM_MASTERS;
                if (!gnt_vld && m_req_i[j] && (m_we_i[j] || !full)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(j);
                end
            end
        end
    end

    assign s_req_o   = gnt_vld;
    assign s_we_o    = m_we_i[gnt_idx];
    assign s_addr_o  = m_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_wdata_o = m_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign s_be_o    = m_be_i[gnt_idx*BW +: BW];

    assign accept  = s_req_o && s_ack_i;
    assign m_ack_o = accept ? (NUM_MASTERS'(1) << gnt_idx) : '0;
    assign push    = accept && !s_we_o;
    assign pop     = s_resp_i && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked   <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
            err_q    <= 1'b0;
        end else begin
            locked   <= s_req_o && !s_ack_i;
            lock_idx <= gnt_idx;
            if (accept) begin
                if (gnt_idx == IW'(NUM_MASTERS - 1)) rr_ptr <= '0;
                else                                 rr_ptr <= gnt_idx + 1'b1;
            end
            if (s_resp_i && empty) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    mem_split_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .din    (tag_t'(gnt_idx)),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

    always_comb begin
        resp_vec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            resp_vec[i] = pop && (head == tag_t'(i));
        end
    end

`ifdef MEM_SPLIT_ARBITER_RESP_REG_EN
    logic [NUM_MASTERS-1:0] resp_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            resp_q <= resp_vec;
            if (pop) rdata_q <= s_rdata_i;
        end
    end

    assign m_resp_o  = resp_q;
    assign m_rdata_o = rdata_q;
`else
    assign m_resp_o  = resp_vec;
    assign m_rdata_o = s_rdata_i;
`endif

endmodule

// File: tb/tb_mem_split_arbiter.sv
// Scoreboard bench for mem_split_arbiter (4 masters, 4 outstanding).
// Response latency tracks MEM_SPLIT_ARBITER_RESP_REG_EN.
module tb_mem_split_arbiter;

`ifdef MEM_SPLIT_ARBITER_RESP_REG_EN
    localparam int RESP_LAT = 1;
`else
    localparam int RESP_LAT = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic [3:0]   m_req;
    logic [3:0]   m_we;
    logic [127:0] m_addr;
    logic [127:0] m_wdata;
    logic [15:0]  m_be;
    logic [3:0]   m_resp;
    logic [3:0]   m_ack;
    logic [31:0]  m_rdata;
    logic         s_req;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_be;
    logic         s_ack;
    logic         s_resp;
    logic [31:0]  s_rdata;
    logic         err;

    typedef struct {
        int          due;
        logic [3:0]  vec;
        logic [31:0] data;
    } rsp_t;

    int   rd_q[$];
    rsp_t out_q[$];
    int   cyc;
    int   total;
    int   passed;

    mem_split_arbiter #(
        .NUM_MASTERS     (4),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_be_i    (m_be),
        .m_resp_o  (m_resp),
        .m_ack_o   (m_ack),
        .m_rdata_o (m_rdata),
        .s_req_o   (s_req),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_be_o    (s_be),
        .s_ack_i   (s_ack),
        .s_resp_i  (s_resp),
        .s_rdata_i (s_rdata),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] wd_of(input int i);
        return 32'h5A5A_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] be_of(input int i);
        return 4'(i + 1);
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        rd_q.delete();
        out_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        m_req  = 4'b1000;
        m_we   = 4'b1000;
        s_ack  = 1'b1;
        s_resp = 1'b0;
        #1;
        total++;
        if (err !== 1'b0 || m_resp !== 4'h0)
            $display("FAIL reset_state: err=%b resp=%b want 0/0", err, m_resp);
        else passed++;
        do_reset();
        #4;
        total++;
        if (s_req !== 1'b0 || m_ack !== 4'h0)
            $display("FAIL reset_idle: s_req=%b ack=%b want 0", s_req, m_ack);
        else passed++;
        @(posedge clk); #1;
        m_req = 4'b1000;
        m_we  = 4'b1000;
        s_ack = 1'b1;
        #4;
        total++;
        if (s_req !== 1'b1 || s_addr !== addr_of(3) || m_ack !== 4'b1000)
            $display("FAIL reset_first_gnt: req=%b addr=%h ack=%b want 1/%h/1000",
                     s_req, s_addr, m_ack, addr_of(3));
        else passed++;
        @(posedge clk); #1;
        m_req = '0;
        m_we  = '0;
    endtask

    task automatic test_rr();
        rsp_t r;
        int   g;
        do_reset();
        s_ack = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            m_req   = (c < 8) ? 4'hF : 4'h0;
            s_resp  = (c >= 1 && c < 9);
            s_rdata = 32'hD000_0000 + 32'(c);
            if (s_resp && rd_q.size() > 0) begin
                g      = rd_q.pop_front();
                r.due  = cyc + RESP_LAT;
                r.vec  = 4'(1 << g);
                r.data = s_rdata;
                out_q.push_back(r);
            end
            if (c < 8) rd_q.push_back(c % 4);
            #4;
            if (c < 8) begin
                total++;
                if (s_addr !== addr_of(c % 4) || m_ack !== 4'(1 << (c % 4)))
                    $display("FAIL rr_gnt c%0d: addr=%h ack=%b want %h/%b",
                             c, s_addr, m_ack, addr_of(c % 4), 4'(1 << (c % 4)));
                else passed++;
            end
            total++;
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                r = out_q.pop_front();
                if (m_resp !== r.vec || m_rdata !== r.data)
                    $display("FAIL rr_resp c%0d: resp=%b data=%h want %b/%h",
                             c, m_resp, m_rdata, r.vec, r.data);
                else passed++;
            end else if (m_resp !== 4'h0)
                $display("FAIL rr_noresp c%0d: resp=%b want 0000", c, m_resp);
            else passed++;
        end
        total++;
        if (err !== 1'b0 || out_q.size() != 0)
            $display("FAIL rr_end: err=%b left=%0d want 0/0", err, out_q.size());
        else passed++;
    endtask

    task automatic test_lock();
        logic [3:0] tq [9] = '{4'h4, 4'h6, 4'h6, 4'h6, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       ta [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic       tr [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        int         tg [9] = '{2, 2, 2, 2, 1, -1, -1, -1, -1};
        rsp_t r;
        int   g;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            m_req   = tq[c];
            m_we    = '0;
            s_ack   = ta[c];
            s_resp  = tr[c];
            s_rdata = $urandom;
            if (s_resp && rd_q.size() > 0) begin
                g      = rd_q.pop_front();
                r.due  = cyc + RESP_LAT;
                r.vec  = 4'(1 << g);
                r.data = s_rdata;
                out_q.push_back(r);
            end
            if (tg[c] >= 0 && ta[c]) rd_q.push_back(tg[c]);
            #4;
            total++;
            if (s_req !== (tg[c] >= 0))
                $display("FAIL lock_req c%0d: s_req=%b want %b", c, s_req, tg[c] >= 0);
            else passed++;
            if (tg[c] >= 0) begin
                total++;
                if (s_addr !== addr_of(tg[c]))
                    $display("FAIL lock_addr c%0d: addr=%h want %h",
                             c, s_addr, addr_of(tg[c]));
                else passed++;
            end
            total++;
            if (m_ack !== ((tg[c] >= 0 && ta[c]) ? 4'(1 << tg[c]) : 4'h0))
                $display("FAIL lock_ack c%0d: ack=%b", c, m_ack);
            else passed++;
            total++;
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                r = out_q.pop_front();
                if (m_resp !== r.vec || m_rdata !== r.data)
                    $display("FAIL lock_resp c%0d: resp=%b data=%h want %b/%h",
                             c, m_resp, m_rdata, r.vec, r.data);
                else passed++;
            end else if (m_resp !== 4'h0)
                $display("FAIL lock_noresp c%0d: resp=%b want 0000", c, m_resp);
            else passed++;
        end
    endtask

    task automatic test_full();
        logic [3:0] tq [14] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h9, 4'h1, 4'h1,
                                4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0] tw [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       tr [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0};
        int         tg [14] = '{0, 1, 2, 3, 3, -1, -1, 0, -1, -1, -1, -1, -1, -1};
        rsp_t r;
        int   g;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            m_req   = tq[c];
            m_we    = tw[c];
            s_ack   = 1'b1;
            s_resp  = tr[c];
            s_rdata = $urandom;
            if (s_resp && rd_q.size() > 0) begin
                g      = rd_q.pop_front();
                r.due  = cyc + RESP_LAT;
                r.vec  = 4'(1 << g);
                r.data = s_rdata;
                out_q.push_back(r);
            end
            if (tg[c] >= 0 && !tw[c][tg[c]]) rd_q.push_back(tg[c]);
            #4;
            total++;
            if (s_req !== (tg[c] >= 0))
                $display("FAIL full_req c%0d: s_req=%b want %b", c, s_req, tg[c] >= 0);
            else passed++;
            if (tg[c] >= 0) begin
                total++;
                if (s_addr !== addr_of(tg[c]) || s_we !== tw[c][tg[c]] ||
                    s_wdata !== wd_of(tg[c]) || s_be !== be_of(tg[c]))
                    $display("FAIL full_bus c%0d: addr=%h we=%b wd=%h be=%h want m%0d",
                             c, s_addr, s_we, s_wdata, s_be, tg[c]);
                else passed++;
            end
            total++;
            if (m_ack !== ((tg[c] >= 0) ? 4'(1 << tg[c]) : 4'h0))
                $display("FAIL full_ack c%0d: ack=%b", c, m_ack);
            else passed++;
            total++;
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                r = out_q.pop_front();
                if (m_resp !== r.vec || m_rdata !== r.data)
                    $display("FAIL full_resp c%0d: resp=%b data=%h want %b/%h",
                             c, m_resp, m_rdata, r.vec, r.data);
                else passed++;
            end else if (m_resp !== 4'h0)
                $display("FAIL full_noresp c%0d: resp=%b want 0000", c, m_resp);
            else passed++;
        end
        total++;
        if (err !== 1'b0)
            $display("FAIL full_err: err=%b want 0", err);
        else passed++;
    endtask

    task automatic test_err();
        do_reset();
        @(posedge clk); #1;
        s_resp  = 1'b1;
        s_rdata = 32'hBAD0_0001;
        #4;
        total++;
        if (m_resp !== 4'h0 || err !== 1'b0)
            $display("FAIL err_pulse: resp=%b err=%b want 0000/0", m_resp, err);
        else passed++;
        @(posedge clk); #1;
        s_resp = 1'b0;
        #4;
        total++;
        if (m_resp !== 4'h0 || err !== 1'b1)
            $display("FAIL err_set: resp=%b err=%b want 0000/1", m_resp, err);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1)
            $display("FAIL err_sticky: err=%b want 1", err);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            m_req = 4'(1 << c);
            #4;
            total++;
            if (m_ack !== 4'(1 << c))
                $display("FAIL mid_ack c%0d: ack=%b want %b", c, m_ack, 4'(1 << c));
            else passed++;
        end
        @(posedge clk); #1;
        m_req = '0;
        s_ack = 1'b0;
        #4 rst_n = 1'b0;
        #1;
        total++;
        if (err !== 1'b0 || m_resp !== 4'h0 || s_req !== 1'b0 || m_ack !== 4'h0)
            $display("FAIL mid_rst: err=%b resp=%b req=%b ack=%b want 0",
                     err, m_resp, s_req, m_ack);
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        s_resp = 1'b1;
        #4;
        total++;
        if (m_resp !== 4'h0)
            $display("FAIL mid_resp: resp=%b want 0000", m_resp);
        else passed++;
        @(posedge clk); #1;
        s_resp = 1'b0;
        #4;
        total++;
        if (err !== 1'b1 || m_resp !== 4'h0)
            $display("FAIL mid_err: err=%b resp=%b want 1/0000", err, m_resp);
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        total  = 0;
        passed = 0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i*32 +: 32]  = addr_of(i);
            m_wdata[i*32 +: 32] = wd_of(i);
            m_be[i*4 +: 4]      = be_of(i);
        end
        test_reset();
        test_rr();
        test_lock();
        test_full();
        test_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
